// File: rtl/xnor_scr_pkg.sv
// Shared definitions for the XNOR scrambler/descrambler pair: LFSR geometry,
// tap constants, control state encoding and the n-step LFSR advance function.
package xnor_scr_pkg;

    localparam int LFSR_W = 16;
    // Taps of x^16+x^14+x^13+x^11+1 as state bit positions 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step_n(input logic [LFSR_W-1:0] s,
                                                      input int n);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            v = lfsr_step(v);
        end
        return v;
    endfunction

endpackage

// File: rtl/parallel_gate_xnor.sv
// Bitwise XNOR of two 2**S-bit words; purely combinational gate primitive.
module parallel_gate_xnor #(
    parameter int S = 3
) (
    input  logic [(1<<S)-1:0] in1,
    input  logic [(1<<S)-1:0] in2,
    output logic [(1<<S)-1:0] out
);

    assign out = ~(in1 ^ in2);

endmodule

// File: rtl/parallel_xnor_descrambler_lfsr_advance_n.sv
// Combinational unrolled LFSR advance by N steps; shared with the transmit-side
// scrambler so both ends derive an identical keystream.
module lfsr_advance_n
    import xnor_scr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] state_o
);

    assign state_o = lfsr_step_n(state_i, N);

endmodule

// File: rtl/parallel_xnor_descrambler.sv
// Receive-side XNOR descrambler: one registered output word per accepted input,
// keystream taken from a 16-bit Fibonacci LFSR advanced W steps per word.
module parallel_xnor_descrambler
    import xnor_scr_pkg::*;
#(
    parameter int              S        = 3,
    parameter logic [LFSR_W-1:0] SEED_DEF = 16'h0001
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed,
    input  logic                in_valid,
    input  logic [(1<<S)-1:0]   in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [(1<<S)-1:0]   out_data,
    input  logic                out_ready,
    output logic                locked,
    output logic [15:0]         word_cnt
);

    localparam int W = 1 << S;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        out_data_q, out_data_d;
    logic [15:0]         word_cnt_q, word_cnt_d;

    logic [LFSR_W-1:0]   lfsr_adv_s;
    logic [W-1:0]        key_s;
    logic [W-1:0]        plain_s;
    logic                accept_s;
    logic                seed_ok_s;

    assign key_s     = lfsr_q[W-1:0];
    assign seed_ok_s = (seed != 16'h0000);
    assign locked    = (state_q == RUN);
    // A seed load owns the cycle, so no word can be keyed with a stale state
    assign in_ready  = locked && (!out_valid_q || out_ready) && !seed_load;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = word_cnt_q;

    lfsr_advance_n #(.N(W)) u_adv (
        .state_i (lfsr_q),
        .state_o (lfsr_adv_s)
    );

    parallel_gate_xnor #(.S(S)) u_xnor (
        .in1 (in_data),
        .in2 (key_s),
        .out (plain_s)
    );

    // Control FSM next state plus LFSR and word counter updates
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        word_cnt_d = word_cnt_q;
        if (accept_s) begin
            lfsr_d     = lfsr_adv_s;
            word_cnt_d = word_cnt_q + 16'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end
        case (state_q)
            RUN: begin
                if (seed_load && seed_ok_s) begin
                    lfsr_d     = seed;
                    word_cnt_d = 16'd0;
                end else if (seed_load) begin
                    state_d = UNSEEDED;
                end else begin
                    state_d = RUN;
                end
            end
            UNSEEDED: begin
                if (seed_load && seed_ok_s) begin
                    lfsr_d     = seed;
                    word_cnt_d = 16'd0;
                    state_d    = RUN;
                end else begin
                    state_d = UNSEEDED;
                end
            end
            default: begin
                state_d = UNSEEDED;
            end
        endcase
    end

    // Output word register: load on accept, drop valid once consumed
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = plain_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            lfsr_q      <= SEED_DEF;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            word_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

endmodule
